// File: rtl/tpu_pkg.sv
// Shared types for the systolic-array support blocks: element width,
// drain engine state encoding and the packed result-row type.
package tpu_pkg;

  localparam int unsigned DATA_WIDTH    = 8;
  localparam int unsigned COLUMN_NUMBER = 4;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    SEND
  } drain_state_t;

  // One C row; element c sits at bits [c*DATA_WIDTH +: DATA_WIDTH].
  typedef logic [COLUMN_NUMBER-1:0][DATA_WIDTH-1:0] drain_row_t;

  // Saturate an 8-bit job dimension to the physical array size.
  function automatic logic [7:0] clamp_size(input logic [7:0] size,
                                            input int unsigned limit);
    return (32'(size) > limit) ? 8'(limit) : size;
  endfunction

endpackage

// File: rtl/drain_row_buffer.sv
// Row store for result_drain: DEPTH x ROW_W register file with one
// synchronous write port and one combinational read port. Not reset;
// contents are only read after being written by the current job.
module drain_row_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned ROW_W = 32,
  parameter int unsigned IDX_W = 2
) (
  input  logic             clk_i,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [ROW_W-1:0] wr_data_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [ROW_W-1:0] rd_data_o
);

  logic [ROW_W-1:0] mem_q [DEPTH];

  // Capture one drained row per enabled cycle.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_idx_i];

endmodule

// File: rtl/result_drain.sv
// Drain-side engine for the systolic array. Shifts accumulated rows out of
// the array (bottom row first), keeps the valid ones in row order and
// streams them out over valid/ready. All outputs are registered.
// Optional: define DRAIN_COLUMN_MASK_EN to zero out_data columns >= cols.
module result_drain #(
  parameter int unsigned ROW_NUMBER    = 4,
  parameter int unsigned COLUMN_NUMBER = tpu_pkg::COLUMN_NUMBER,
  parameter int unsigned DATA_WIDTH    = tpu_pkg::DATA_WIDTH
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic [7:0]                          size_row_A,
  input  logic [7:0]                          size_column_B,
  input  logic [COLUMN_NUMBER*DATA_WIDTH-1:0] down_out,
  output logic                                through,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [COLUMN_NUMBER*DATA_WIDTH-1:0] out_data,
  output logic [7:0]                          out_row,
  output logic                                busy,
  output logic                                done
);

  import tpu_pkg::drain_state_t, tpu_pkg::IDLE, tpu_pkg::DRAIN, tpu_pkg::SEND;
  import tpu_pkg::clamp_size;

  localparam int unsigned ROW_W = COLUMN_NUMBER * DATA_WIDTH;
  localparam int unsigned IDX_W = (ROW_NUMBER > 1) ? $clog2(ROW_NUMBER) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROW_NUMBER - 1);

  drain_state_t     state_q, state_d;
  logic [IDX_W-1:0] d_q, d_d;
  logic [IDX_W-1:0] k_q, k_d;
  logic [7:0]       rows_q, rows_d;
  logic [7:0]       cols_q, cols_d;
  logic             through_q, through_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [ROW_W-1:0] out_data_q, out_data_d;
  logic [7:0]       out_row_q, out_row_d;

  logic [IDX_W-1:0] drain_row;
  logic [IDX_W-1:0] rd_idx;
  logic [ROW_W-1:0] rd_data;
  logic             wr_en;
  logic [ROW_W-1:0] col_mask;

  // Array emits its bottom row first, so drain step d carries row N-1-d.
  assign drain_row = LAST_IDX - d_q;
  // Read port looks one row ahead so the next row is ready at handshake.
  assign rd_idx    = k_q + IDX_W'(1);

  drain_row_buffer #(
    .DEPTH (ROW_NUMBER),
    .ROW_W (ROW_W),
    .IDX_W (IDX_W)
  ) u_buf (
    .clk_i     (clk),
    .wr_en_i   (wr_en),
    .wr_idx_i  (drain_row),
    .wr_data_i (down_out),
    .rd_idx_i  (rd_idx),
    .rd_data_o (rd_data)
  );

`ifdef DRAIN_COLUMN_MASK_EN
  // Columns at or beyond the latched width read as zero on the output only.
  always_comb begin
    col_mask = '0;
    for (int unsigned c = 0; c < COLUMN_NUMBER; c++) begin
      if (c < 32'(cols_q)) begin
        col_mask[c*DATA_WIDTH +: DATA_WIDTH] = '1;
      end
    end
  end
`else
  assign col_mask = '1;
  logic unused_cols;
  assign unused_cols = ^cols_q;
`endif

  // Next-state, counters and registered-output values.
  always_comb begin
    state_d     = state_q;
    d_d         = d_q;
    k_d         = k_q;
    rows_d      = rows_q;
    cols_d      = cols_q;
    through_d   = 1'b0;
    out_valid_d = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    out_data_d  = out_data_q;
    out_row_d   = out_row_q;
    wr_en       = 1'b0;

    unique case (state_q)
      IDLE: begin
        out_data_d = '0;
        out_row_d  = '0;
        if (start) begin
          state_d   = DRAIN;
          rows_d    = clamp_size(size_row_A, ROW_NUMBER);
          cols_d    = clamp_size(size_column_B, COLUMN_NUMBER);
          d_d       = '0;
          through_d = 1'b1;
          busy_d    = 1'b1;
        end
      end

      DRAIN: begin
        wr_en = (8'(drain_row) < rows_q);
        if (d_q == LAST_IDX) begin
          if (rows_q == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            // Row 0 is being written on this same edge, so present it
            // straight from the array instead of from the buffer.
            state_d     = SEND;
            k_d         = '0;
            busy_d      = 1'b1;
            out_valid_d = 1'b1;
            out_row_d   = '0;
            out_data_d  = down_out & col_mask;
          end
        end else begin
          d_d       = d_q + IDX_W'(1);
          through_d = 1'b1;
          busy_d    = 1'b1;
        end
      end

      SEND: begin
        busy_d      = 1'b1;
        out_valid_d = 1'b1;
        if (out_valid_q && out_ready) begin
          if (8'(k_q) == rows_q - 8'd1) begin
            state_d     = IDLE;
            busy_d      = 1'b0;
            out_valid_d = 1'b0;
            done_d      = 1'b1;
            out_data_d  = '0;
            out_row_d   = '0;
          end else begin
            k_d        = rd_idx;
            out_row_d  = 8'(rd_idx);
            out_data_d = rd_data & col_mask;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      d_q         <= '0;
      k_q         <= '0;
      rows_q      <= '0;
      cols_q      <= '0;
      through_q   <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_data_q  <= '0;
      out_row_q   <= '0;
    end else begin
      state_q     <= state_d;
      d_q         <= d_d;
      k_q         <= k_d;
      rows_q      <= rows_d;
      cols_q      <= cols_d;
      through_q   <= through_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      out_data_q  <= out_data_d;
      out_row_q   <= out_row_d;
    end
  end

  assign through   = through_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign out_data  = out_data_q;
  assign out_row   = out_row_q;

endmodule

// File: tb/tb_result_drain.sv
// Bench for result_drain: directed and randomized drain jobs checked
// against a row-order model of the drain (row k = value seen at step N-1-k).
module tb_result_drain;
  import tpu_pkg::*;

  localparam int unsigned RN = 4;
  localparam int unsigned CN = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned RW = CN * DW;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [7:0]    size_row_A;
  logic [7:0]    size_column_B;
  logic [RW-1:0] down_out;
  logic          through;
  logic          out_valid;
  logic          out_ready;
  logic [RW-1:0] out_data;
  logic [7:0]    out_row;
  logic          busy;
  logic          done;

  int n_cmp = 0;
  int n_bad = 0;

  // Values presented on down_out at drain steps 0..RN-1.
  logic [RW-1:0] drain_vals [RN];

  result_drain #(
    .ROW_NUMBER    (RN),
    .COLUMN_NUMBER (CN),
    .DATA_WIDTH    (DW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .size_row_A    (size_row_A),
    .size_column_B (size_column_B),
    .down_out      (down_out),
    .through       (through),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_row       (out_row),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Expected row k: the array's bottom row leaves first, so row k was seen
  // at drain step RN-1-k; columns at or beyond lim are zero.
  function automatic logic [RW-1:0] exp_row(input int k, input int lim);
    drain_row_t r;
    r = drain_vals[RN-1-k];
    for (int c = 0; c < int'(CN); c++) begin
      if (c >= lim) r[c] = '0;
    end
    return r;
  endfunction

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_through"}, through, 1'b0);
    chk({tag, "_valid"}, out_valid, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_row"}, out_row, 8'd0);
    chk({tag, "_data"}, out_data, '0);
  endtask

  // One job: start, drain RN steps, then receive rows with 'stall' not-ready
  // cycles before each accept. b2b issues start in the current cycle (the
  // done cycle of the previous job). abort_k >= 0 applies reset while row
  // abort_k is presented.
  task automatic run_job(input logic [7:0] sr, input logic [7:0] sc, input int stall,
                         input bit busy_start, input int abort_k, input bit b2b);
    int rows;
    int lim;
    rows = (int'(sr) > int'(RN)) ? int'(RN) : int'(sr);
`ifdef DRAIN_COLUMN_MASK_EN
    lim = (int'(sc) > int'(CN)) ? int'(CN) : int'(sc);
`else
    lim = CN;
`endif
    if (!b2b) @(negedge clk);
    start         = 1'b1;
    size_row_A    = sr;
    size_column_B = sc;
    down_out      = RW'($urandom);
    for (int d = 0; d < int'(RN); d++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy_start && d == 1) begin
        start         = 1'b1;
        size_row_A    = 8'd1;
        size_column_B = 8'd1;
      end
      chk("through_drain", through, 1'b1);
      chk("busy_drain", busy, 1'b1);
      chk("valid_drain", out_valid, 1'b0);
      chk("done_drain", done, 1'b0);
      down_out = drain_vals[d];
    end
    @(negedge clk);
    start    = 1'b0;
    down_out = RW'($urandom);
    chk("through_after", through, 1'b0);
    if (rows == 0) begin
      chk("done_empty", done, 1'b1);
      chk("valid_empty", out_valid, 1'b0);
      chk("busy_empty", busy, 1'b0);
      return;
    end
    for (int k = 0; k < rows; k++) begin
      for (int s = 0; s <= stall; s++) begin
        chk("valid_send", out_valid, 1'b1);
        chk("row_send", out_row, 8'(k));
        chk("data_send", out_data, exp_row(k, lim));
        chk("done_send", done, 1'b0);
        chk("busy_send", busy, 1'b1);
        if (k == abort_k && s == stall) begin
          reset = 1'b1;
          @(negedge clk);
          reset = 1'b0;
          chk_idle_zero("after_reset");
          return;
        end
        out_ready = (s == stall);
        @(negedge clk);
      end
    end
    chk("done_end", done, 1'b1);
    chk("valid_end", out_valid, 1'b0);
    chk("busy_end", busy, 1'b0);
    chk("row_end", out_row, 8'd0);
  endtask

  initial begin
    logic [7:0] col0 [RN];
    reset         = 1'b1;
    start         = 1'b0;
    out_ready     = 1'b0;
    size_row_A    = '0;
    size_column_B = '0;
    down_out      = '0;
    repeat (2) @(negedge clk);
    chk_idle_zero("reset");
    reset = 1'b0;

    // Basic 2x1 job, column 0 = AA, BB, 122, 50; other columns 0x11.
    col0 = '{8'hAA, 8'hBB, 8'd122, 8'd50};
    for (int d = 0; d < int'(RN); d++) drain_vals[d] = {8'h11, 8'h11, 8'h11, col0[d]};
    out_ready = 1'b1;
    run_job(8'd2, 8'd1, 0, 1'b0, -1, 1'b0);

    // Same job under backpressure.
    run_job(8'd2, 8'd1, 3, 1'b0, -1, 1'b0);

    // Full 4x4 job with 0x40..0x43 on all columns.
    for (int d = 0; d < int'(RN); d++) drain_vals[d] = {4{8'(8'h40 + d)}};
    out_ready = 1'b1;
    run_job(8'd4, 8'd4, 0, 1'b0, -1, 1'b0);

    // Empty job, then an oversized one (clamped to 4).
    run_job(8'd0, 8'd2, 0, 1'b0, -1, 1'b0);
    for (int d = 0; d < int'(RN); d++) drain_vals[d] = RW'($urandom);
    run_job(8'd9, 8'd9, 0, 1'b0, -1, 1'b0);

    // start pulsed during DRAIN with other sizes must be ignored.
    for (int d = 0; d < int'(RN); d++) drain_vals[d] = RW'($urandom);
    run_job(8'd3, 8'd2, 1, 1'b1, -1, 1'b0);

    // Reset while row 1 is presented, then a fresh job.
    for (int d = 0; d < int'(RN); d++) drain_vals[d] = RW'($urandom);
    run_job(8'd4, 8'd4, 1, 1'b0, 1, 1'b0);
    for (int d = 0; d < int'(RN); d++) drain_vals[d] = RW'($urandom);
    run_job(8'd2, 8'd3, 0, 1'b0, -1, 1'b0);

    // Randomized jobs, every other one started in the previous done cycle.
    for (int i = 0; i < 10; i++) begin
      for (int d = 0; d < int'(RN); d++) drain_vals[d] = RW'($urandom);
      run_job(8'($urandom_range(0, 6)), 8'($urandom_range(0, 6)),
              int'($urandom_range(0, 2)), 1'b0, -1, (i % 2) == 1);
    end

    @(negedge clk);
    chk("idle_final_busy", busy, 1'b0);
    chk("idle_final_done", done, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/result_drain.md
# result_drain

Drain-side engine for the systolic array. After accumulation, it asserts `through` so the array shifts its accumulated rows out of `down_out`, bottom row first. It captures only the valid result rows into an internal buffer and restores their natural order (row 0 first). It then streams them to downstream logic over a valid/ready interface. It sits between `array.down_out` and the C-matrix consumer, and replaces ad-hoc capture into a C cache in the top level.

## Interface
- `ROW_NUMBER`, 4: array rows; also the drain length in cycles.
- `COLUMN_NUMBER`, 4: array columns; number of elements per row.
- `DATA_WIDTH`, 8: element width.

- `clk` in 1: single clock; all logic on posedge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle request to drain; accepted only when `busy`=0.
- `size_row_A` in 8: number of valid C rows.
- `size_column_B` in 8: number of valid C columns.
- `down_out` in `COLUMN_NUMBER`×`DATA_WIDTH`: bottom-edge outputs of the array; column c is at bits [c*DATA_WIDTH +: DATA_WIDTH].
- `through` out 1: drives `array.through`.
- `out_valid` out 1: a result row is presented.
- `out_ready` in 1: downstream accepts the row.
- `out_data` out `COLUMN_NUMBER`×`DATA_WIDTH`: one C row, same packing as `down_out`.
- `out_row` out 8: row index of `out_data`.
- `busy` out 1: high in DRAIN or SEND.
- `done` out 1: one-cycle pulse at the end of a job.

## Operation
- States: IDLE, DRAIN, SEND.
- IDLE → DRAIN on `start`:
  - latch `size_row_A` into `rows`, clamped to `ROW_NUMBER`.
  - latch `size_column_B` into `cols`, clamped to `COLUMN_NUMBER`.
  - clear the drain counter d.
- DRAIN:
  - `through`=1 for exactly `ROW_NUMBER` cycles, d = 0..ROW_NUMBER-1.
  - At each edge, `down_out` carries array row r = ROW_NUMBER-1-d.
  - If r < `rows`, store it into `buf[r]`; otherwise discard it.
  - After d = ROW_NUMBER-1: go to SEND with the send index k=0. If `rows`=0, go to IDLE and pulse `done` instead.
- SEND:
  - `out_valid`=1, `out_data`=`buf[k]`, `out_row`=k.
  - On `out_valid && out_ready`, k increments.
  - The handshake with k=`rows`-1 returns to IDLE and pulses `done` on the next cycle.
  - `out_data` and `out_row` are held stable while `out_valid && !out_ready`.
- `start` while `busy` is ignored; it is neither queued nor able to corrupt the latched sizes.
- Reset (including mid-DRAIN or mid-SEND):
  - next cycle: IDLE, `through`=0, `out_valid`=0, `busy`=0, `done`=0, `out_row`=0, `out_data`=0.
  - buffer contents are undefined after reset and are never exposed.

## Timing
- All outputs are registered.
- `start` sampled at edge t:
  - `busy` and `through` are high from cycle t+1.
  - `through` is high for cycles t+1 .. t+ROW_NUMBER.
- `out_valid` rises at cycle t+ROW_NUMBER+1; `through` is already 0 that cycle.
- With `out_ready` held high:
  - one row per cycle.
  - last row at cycle t+ROW_NUMBER+`rows`.
  - `done` and `busy`=0 at the following cycle.
- `done` and `out_valid` are never high in the same cycle.
- A new `start` is accepted in the same cycle that `done` is high.

## Configuration
- `DRAIN_COLUMN_MASK_EN` defined:
  - `out_data` elements with column index ≥ `cols` are forced to 0.
  - stored buffer contents are unaffected.
- `DRAIN_COLUMN_MASK_EN` undefined:
  - `out_data` is the raw captured row.
  - `cols` is latched but unused.

## Structure
- Shared package `tpu_pkg` holds:
  - `DATA_WIDTH`.
  - the `drain_state_t` enum {IDLE, DRAIN, SEND}.
  - a row typedef: packed array [COLUMN_NUMBER] of logic [DATA_WIDTH-1:0].
- One sub-module, `drain_row_buffer`:
  - `ROW_NUMBER`-deep register file.
  - one write port (index r, enable), one read port (index k).
  - synchronous write, combinational read.
- The FSM, counters and output registers live in `result_drain`.

## Test plan
All scenarios use `ROW_NUMBER`=`COLUMN_NUMBER`=4.
- **Basic 2×1 job.** `size_row_A`=2, `size_column_B`=1, `out_ready`=1. `down_out` column 0 over the 4 DRAIN cycles = 0xAA, 0xBB, 122, 50; other columns 0x11.
  - Expect `through` high for exactly 4 cycles.
  - Then rows (0, col0=50) and (1, col0=122).
  - Columns 1..3 = 0 with the mask; 0x11 without.
  - Then `done`.
- **Backpressure.** Same job with `out_ready` low for 3 cycles on each row: `out_data` and `out_row` stay stable, no row is lost or duplicated, `done` comes only after row 1 is accepted.
- **Full job.** `size_row_A`=4, `size_column_B`=4, drain values 0x40..0x43 on all columns: rows 0..3 come out as 0x43, 0x42, 0x41, 0x40.
- **Edge sizes.**
  - `size_row_A`=0: `through` runs 4 cycles, no `out_valid`, `done` at cycle t+5.
  - `size_row_A`=9: behaves as 4.
- **Start while busy / reset.**
  - `start` pulsed during DRAIN with different sizes: ignored, original job completes unchanged.
  - `reset` during SEND: the next cycle shows IDLE with all outputs 0; a fresh job then works.
